// File: rtl/core_tlb_maint_pkg.sv
// Shared TLB maintenance types: entry layout, update bus, op codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef _TLB_ENTRY_NUM
`define _TLB_ENTRY_NUM 32
`endif

package core_tlb_maint_pkg;

  // The update bus width is fixed here; the sequencer's TLB_ENTRY_NUM must match.
  localparam int TLB_ENTRY_NUM_DEF = `_TLB_ENTRY_NUM;

  // Page size code for a 4K page; only these pages compare the low VPPN bits.
  localparam logic [5:0] PS_4K = 6'd12;

  typedef enum logic [1:0] {
    TLB_OP_WR   = 2'd0,
    TLB_OP_FILL = 2'd1,
    TLB_OP_RD   = 2'd2,
    TLB_OP_INV  = 2'd3
  } tlb_op_e;

  // INVTLB op codes; anything above INV_OP_MAX is illegal.
  localparam logic [4:0] INV_OP_ALL0        = 5'd0;
  localparam logic [4:0] INV_OP_ALL1        = 5'd1;
  localparam logic [4:0] INV_OP_G           = 5'd2;
  localparam logic [4:0] INV_OP_NG          = 5'd3;
  localparam logic [4:0] INV_OP_NG_ASID     = 5'd4;
  localparam logic [4:0] INV_OP_NG_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_OP_G_OR_ASID_VA = 5'd6;
  localparam logic [4:0] INV_OP_MAX         = 5'd6;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
  } tlb_key_t;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_value_t;

  typedef struct packed {
    tlb_key_t        key;
    tlb_value_t [1:0] value;
  } tlb_entry_t;

  typedef struct packed {
    logic [TLB_ENTRY_NUM_DEF-1:0] tlb_we;
    tlb_entry_t                   tlb_w_entry;
  } tlb_update_req_t;

endpackage

// File: rtl/tlb_inv_match.sv
// INVTLB predicate: does this key fall under the given op/asid/va.
// Latency: combinational.
// Backpressure: none; the caller gates with the entry valid bit.
module tlb_inv_match
  import core_tlb_maint_pkg::*;
(
  input  tlb_key_t    key,
  input  logic [4:0]  op,
  input  logic [9:0]  asid,
  input  logic [31:0] va,
  output logic        hit
);

  logic asid_hit;
  logic va_hit;
  logic unused_bits;

  // Valid bit is qualified by the caller; page offset bits never take part.
  assign unused_bits = ^{key.e, va[12:0]};

  assign asid_hit = (key.asid == asid);

  // Large pages compare only the upper VPPN bits; 4K pages compare all of it.
  assign va_hit = (va[31:23] == key.vppn[18:10]) &&
                  ((key.ps != PS_4K) || (va[22:13] == key.vppn[9:0]));

  // Select the predicate for the op; illegal ops never match.
  always_comb begin
    hit = 1'b0;
    case (op)
      INV_OP_ALL0, INV_OP_ALL1: hit = 1'b1;
      INV_OP_G:                 hit = key.g;
      INV_OP_NG:                hit = !key.g;
      INV_OP_NG_ASID:           hit = !key.g && asid_hit;
      INV_OP_NG_ASID_VA:        hit = !key.g && asid_hit && va_hit;
      INV_OP_G_OR_ASID_VA:      hit = (key.g || asid_hit) && va_hit;
      default:                  hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_tlb_maint.sv
// TLB maintenance sequencer (WR/FILL/RD/INVTLB) owning the shared TLB update bus and a shadow of all entries.
// Latency: WR/FILL/RD/illegal INV done at +1 cycle; INV writes at +1..+N, done at +N.
// Backpressure: one op at a time; req_ready_o low outside IDLE and during the done cycle.
module core_tlb_maint
  import core_tlb_maint_pkg::*;
#(
  parameter int TLB_ENTRY_NUM = `_TLB_ENTRY_NUM
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  tlb_op_e                          req_op_i,
  input  logic [$clog2(TLB_ENTRY_NUM)-1:0] req_index_i,
  input  tlb_entry_t                       req_entry_i,
  input  logic [4:0]                       inv_op_i,
  input  logic [9:0]                       inv_asid_i,
  input  logic [31:0]                      inv_va_i,
  output tlb_update_req_t                  tlb_update_req_o,
  output logic                             done_o,
  output logic                             err_o,
  output tlb_entry_t                       rd_entry_o,
  output logic [$clog2(TLB_ENTRY_NUM)-1:0] fill_index_o
);

  localparam int IW = $clog2(TLB_ENTRY_NUM);
  localparam logic [IW-1:0] LAST_IDX = IW'(TLB_ENTRY_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_SCAN  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   scan_idx_q, scan_idx_d;
  logic [IW-1:0]   fill_cnt_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [31:0]     inv_va_q;
  logic            latch_inv;

  // Shadow copy: payload is unreset, validity lives in a separately reset vector.
  tlb_entry_t               shadow_q [TLB_ENTRY_NUM];
  logic [TLB_ENTRY_NUM-1:0] shadow_e_q;

  // Single shadow write port, shared by WR/FILL and scan invalidation.
  logic            sh_we;
  logic [IW-1:0]   sh_idx;
  tlb_entry_t      sh_entry;

  // Next values of the registered outputs.
  tlb_update_req_t upd_d;
  logic            done_d;
  logic            err_d;
  tlb_entry_t      rd_entry_d;
  logic [IW-1:0]   fill_index_d;

  // Invalidate matcher port. Outputs are registered, so the entry for the next
  // output cycle is evaluated one cycle early: index 0 from the live request
  // operands in IDLE, then index i+1 from the latched operands while scanning.
  logic [IW-1:0]   m_idx;
  logic [4:0]      m_op;
  logic [9:0]      m_asid;
  logic [31:0]     m_va;
  tlb_entry_t      m_entry;
  tlb_entry_t      m_clr;
  logic            m_hit;
  logic            scan_step;
  tlb_entry_t      rd_sel;

  assign req_ready_o = (state_q == S_IDLE) && !done_o;

  assign m_idx  = (state_q == S_SCAN) ? scan_idx_q + 1'b1 : '0;
  assign m_op   = (state_q == S_SCAN) ? inv_op_q   : inv_op_i;
  assign m_asid = (state_q == S_SCAN) ? inv_asid_q : inv_asid_i;
  assign m_va   = (state_q == S_SCAN) ? inv_va_q   : inv_va_i;

  // Shadow read ports with the authoritative valid bit merged in.
  always_comb begin
    m_entry            = shadow_q[m_idx];
    m_entry.key.e      = shadow_e_q[m_idx];
    m_clr              = m_entry;
    m_clr.key.e        = 1'b0;
    rd_sel             = shadow_q[req_index_i];
    rd_sel.key.e       = shadow_e_q[req_index_i];
  end

  tlb_inv_match u_inv_match (
    .key  (m_entry.key),
    .op   (m_op),
    .asid (m_asid),
    .va   (m_va),
    .hit  (m_hit)
  );

  // Next state, shadow write and next registered outputs.
  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    latch_inv    = 1'b0;
    scan_step    = 1'b0;
    upd_d        = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rd_entry_d   = rd_entry_o;
    fill_index_d = fill_index_o;
    sh_we        = 1'b0;
    sh_idx       = '0;
    sh_entry     = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          case (req_op_i)
            TLB_OP_WR, TLB_OP_FILL: begin
              sh_idx   = (req_op_i == TLB_OP_FILL) ? fill_cnt_q : req_index_i;
              sh_we    = 1'b1;
              sh_entry = req_entry_i;
              upd_d.tlb_we[sh_idx] = 1'b1;
              upd_d.tlb_w_entry    = req_entry_i;
              if (req_op_i == TLB_OP_FILL) begin
                fill_index_d = fill_cnt_q;
              end
              done_d  = 1'b1;
              state_d = S_WRITE;
            end
            TLB_OP_RD: begin
              rd_entry_d = rd_sel;
              done_d     = 1'b1;
              state_d    = S_READ;
            end
            TLB_OP_INV: begin
              if (inv_op_i <= INV_OP_MAX) begin
                latch_inv  = 1'b1;
                scan_idx_d = '0;
                scan_step  = 1'b1;
                state_d    = S_SCAN;
              end else begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_WRITE, S_READ: begin
        state_d = S_IDLE;
      end
      S_SCAN: begin
        if (scan_idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          scan_idx_d = m_idx;
          scan_step  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A scan step presents entry m_idx next cycle; only valid matching entries are rewritten.
    if (scan_step) begin
      done_d = (m_idx == LAST_IDX);
      if (m_entry.key.e && m_hit) begin
        sh_we    = 1'b1;
        sh_idx   = m_idx;
        sh_entry = m_clr;
        upd_d.tlb_we[m_idx] = 1'b1;
        upd_d.tlb_w_entry   = m_clr;
      end
    end
  end

  // Control state, scan cursor, free-running fill counter and latched INVTLB operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      scan_idx_q <= '0;
      fill_cnt_q <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_va_q   <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      fill_cnt_q <= fill_cnt_q + 1'b1;
      if (latch_inv) begin
        inv_op_q   <= inv_op_i;
        inv_asid_q <= inv_asid_i;
        inv_va_q   <= inv_va_i;
      end
    end
  end

  // Registered update bus and commit-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlb_update_req_o <= '0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      rd_entry_o       <= '0;
      fill_index_o     <= '0;
    end else begin
      tlb_update_req_o <= upd_d;
      done_o           <= done_d;
      err_o            <= err_d;
      rd_entry_o       <= rd_entry_d;
      fill_index_o     <= fill_index_d;
    end
  end

  // Shadow valid bits follow every bus write, so they always mirror the TLBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_e_q <= '0;
    end else if (sh_we) begin
      shadow_e_q[sh_idx] <= sh_entry.key.e;
    end
  end

  // Shadow payload; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (sh_we) begin
      shadow_q[sh_idx] <= sh_entry;
    end
  end

endmodule

// File: tb/tb_core_tlb_maint.sv
// Self-checking bench for core_tlb_maint: directed scenarios plus random ops against an entry-array model.
// Latency: checks done/tlb_we cycle by cycle relative to the acceptance edge.
// Backpressure: checks req_ready_o before every request and during done/scan cycles.
module tb_core_tlb_maint;
  import core_tlb_maint_pkg::*;

  localparam int N  = 32;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid;
  logic            req_ready;
  tlb_op_e         req_op;
  logic [IW-1:0]   req_index;
  tlb_entry_t      req_entry;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [31:0]     inv_va;
  tlb_update_req_t upd;
  logic            done;
  logic            err;
  tlb_entry_t      rd_entry;
  logic [IW-1:0]   fill_index;

  core_tlb_maint #(.TLB_ENTRY_NUM(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_index_i      (req_index),
    .req_entry_i      (req_entry),
    .inv_op_i         (inv_op),
    .inv_asid_i       (inv_asid),
    .inv_va_i         (inv_va),
    .tlb_update_req_o (upd),
    .done_o           (done),
    .err_o            (err),
    .rd_entry_o       (rd_entry),
    .fill_index_o     (fill_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc;
  tlb_entry_t model [N];

  // Cycles since reset release; the fill counter is this value mod N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Invalidate rule written from the entry's point of view.
  function automatic bit inv_hit(tlb_entry_t en, int op, logic [9:0] asid, logic [31:0] va);
    bit same_asid;
    bit same_va;
    if (!en.key.e) return 1'b0;
    same_asid = (en.key.asid == asid);
    if (en.key.ps == 6'd12) same_va = (va[31:13] == en.key.vppn);
    else                    same_va = (va[31:23] == en.key.vppn[18:10]);
    case (op)
      0, 1:    return 1'b1;
      2:       return en.key.g;
      3:       return !en.key.g;
      4:       return !en.key.g && same_asid;
      5:       return !en.key.g && same_asid && same_va;
      6:       return (en.key.g || same_asid) && same_va;
      default: return 1'b0;
    endcase
  endfunction

  function automatic tlb_entry_t rand_entry();
    tlb_entry_t en;
    en = '0;
    en.key.vppn = 19'($urandom);
    en.key.ps   = ($urandom_range(0, 1) != 0) ? 6'd12 : 6'd22;
    en.key.g    = ($urandom_range(0, 3) == 0);
    en.key.asid = 10'($urandom_range(0, 3));
    en.key.e    = ($urandom_range(0, 3) != 0);
    en.value[0] = 26'($urandom);
    en.value[1] = 26'($urandom);
    return en;
  endfunction

  // WR, FILL or RD: done and bus write exactly one cycle after acceptance.
  task automatic do_simple(input tlb_op_e op, input int idx, input tlb_entry_t ent);
    int tgt;
    logic [N-1:0] exp_we;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    tgt = (op == TLB_OP_FILL) ? (cyc % N) : idx;
    req_valid = 1'b1;
    req_op    = op;
    req_index = IW'(idx);
    req_entry = ent;
    @(negedge clk);
    req_valid = 1'b0;
    exp_we = '0;
    if (op != TLB_OP_RD) exp_we[tgt] = 1'b1;
    chk("done_simple", done, 1);
    chk("err_simple", err, 0);
    chk("ready_in_done", req_ready, 0);
    chk("tlb_we_simple", upd.tlb_we, exp_we);
    if (op == TLB_OP_RD) begin
      chk("rd_entry", rd_entry, model[idx]);
    end else begin
      chk("w_entry", upd.tlb_w_entry, ent);
      model[tgt] = ent;
    end
    if (op == TLB_OP_FILL) chk("fill_index", fill_index, tgt);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("tlb_we_clear", upd.tlb_we, 0);
  endtask

  // INVTLB: one bus slot per entry, done on the last; optional reset at scan index abort_at.
  task automatic do_inv(input int op, input logic [9:0] asid, input logic [31:0] va, input int abort_at);
    logic [N-1:0] exp_we;
    bit           hits [N];
    tlb_entry_t   cleared;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = TLB_OP_INV;
    inv_op    = 5'(op);
    inv_asid  = asid;
    inv_va    = va;
    if (op > 6) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("illegal_done", done, 1);
      chk("illegal_err", err, 1);
      chk("illegal_we", upd.tlb_we, 0);
      chk("illegal_ready", req_ready, 0);
      @(negedge clk);
      chk("illegal_done_clear", done, 0);
      chk("illegal_err_clear", err, 0);
      chk("illegal_ready_back", req_ready, 1);
      return;
    end
    for (int i = 0; i < N; i++) hits[i] = inv_hit(model[i], op, asid, va);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      exp_we = '0;
      if (hits[k]) exp_we[k] = 1'b1;
      chk("scan_we", upd.tlb_we, exp_we);
      if (hits[k]) begin
        cleared = model[k];
        cleared.key.e = 1'b0;
        chk("scan_w_entry", upd.tlb_w_entry, cleared);
        model[k] = cleared;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_we", upd.tlb_we, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_rd_entry", rd_entry, 0);
        chk("abort_fill_index", fill_index, 0);
        for (int i = 0; i < N; i++) model[i].key.e = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      chk("scan_done", done, (k == N - 1));
      chk("scan_ready", req_ready, 0);
    end
    @(negedge clk);
    chk("scan_done_clear", done, 0);
    chk("scan_ready_back", req_ready, 1);
  endtask

  initial begin
    tlb_entry_t en;
    int         j;
    logic [31:0] va;

    req_valid = 1'b0;
    req_op    = TLB_OP_WR;
    req_index = '0;
    req_entry = '0;
    inv_op    = '0;
    inv_asid  = '0;
    inv_va    = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_we", upd.tlb_we, 0);
    chk("rst_w_entry", upd.tlb_w_entry, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_entry", rd_entry, 0);
    chk("rst_fill_index", fill_index, 0);
    rst_n = 1'b1;

    // Give every entry a known payload, all invalid.
    for (int i = 0; i < N; i++) begin
      en = rand_entry();
      en.key.e = 1'b0;
      do_simple(TLB_OP_WR, i, en);
    end

    // WR index 5 then read it back.
    en = '0;
    en.key.vppn = 19'h12345;
    en.key.ps   = 6'd12;
    en.key.asid = 10'd3;
    en.key.e    = 1'b1;
    do_simple(TLB_OP_WR, 5, en);
    do_simple(TLB_OP_RD, 5, '0);
    chk("rd_idx5_exact", rd_entry, en);

    // FILL accepted while the counter reads 7.
    while ((cyc % N) != 6) @(negedge clk);
    en = '0;
    en.key.vppn = 19'h00777;
    en.key.ps   = 6'd12;
    en.key.asid = 10'd6;
    en.key.e    = 1'b1;
    do_simple(TLB_OP_FILL, 0, en);
    chk("fill_at_7", fill_index, 7);

    // Entries 0..3, then INV op 4 on asid 4 hits 0 and 2 only.
    for (int i = 0; i < 4; i++) begin
      en = '0;
      en.key.vppn = 19'(16'h0100 + i);
      en.key.ps   = 6'd12;
      en.key.g    = (i == 1);
      en.key.asid = (i == 3) ? 10'd5 : ((i == 1) ? 10'd0 : 10'd4);
      en.key.e    = 1'b1;
      do_simple(TLB_OP_WR, i, en);
    end
    do_inv(4, 10'd4, 32'h0, -1);
    chk("inv4_idx0_invalid", model[0].key.e, 0);
    chk("inv4_idx1_valid", model[1].key.e, 1);

    // INV op 5 with a 4M page and a neighbouring 4K page.
    en = '0;
    en.key.vppn = 19'h00200;
    en.key.ps   = 6'd22;
    en.key.asid = 10'd4;
    en.key.e    = 1'b1;
    do_simple(TLB_OP_WR, 8, en);
    en.key.vppn = 19'h00201;
    en.key.ps   = 6'd12;
    do_simple(TLB_OP_WR, 9, en);
    do_inv(5, 10'd4, 32'h0040_0000, -1);
    do_simple(TLB_OP_RD, 8, '0);
    chk("inv5_4m_cleared", rd_entry.key.e, 0);
    do_simple(TLB_OP_RD, 9, '0);
    chk("inv5_4k_kept", rd_entry.key.e, 1);

    // Illegal INVTLB op.
    do_inv(9, 10'd0, 32'h0, -1);

    // Random mix against the model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_simple(TLB_OP_WR, $urandom_range(0, N - 1), rand_entry());
        4:          do_simple(TLB_OP_FILL, 0, rand_entry());
        5, 6:       do_simple(TLB_OP_RD, $urandom_range(0, N - 1), '0);
        default: begin
          j  = $urandom_range(0, N - 1);
          va = {model[j].key.vppn, 13'($urandom)};
          if ($urandom_range(0, 3) == 0) va = $urandom;
          do_inv($urandom_range(0, 7), 10'($urandom_range(0, 3)), va, -1);
        end
      endcase
    end

    // Reset in the middle of a scan, then every entry reads back invalid.
    en = rand_entry();
    en.key.e = 1'b1;
    do_simple(TLB_OP_WR, 10, en);
    do_inv(0, 10'd0, 32'h0, 10);
    for (int i = 0; i < 4; i++) do_simple(TLB_OP_RD, $urandom_range(0, N - 1), '0);
    do_simple(TLB_OP_RD, 10, '0);
    chk("post_reset_idx10_invalid", rd_entry.key.e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/core_tlb_maint.md
# core_tlb_maint

Sequencer for TLB maintenance instructions (TLBWR, TLBFILL, TLBRD, INVTLB). It sits beside the fetch and data address-translation units and is the sole source of their shared `tlb_update_req_t` write bus. It holds a shadow copy of every TLB entry, which is used for reads and invalidate scans. It runs one operation at a time and signals completion to the commit stage.

## Interface
- `TLB_ENTRY_NUM`, default `` `_TLB_ENTRY_NUM `` (32): number of entries; power of two, 4..64.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: operation request.
- `req_ready_o` output 1: high only in IDLE.
- `req_op_i` input `tlb_op_e` (2b): WR=0, FILL=1, RD=2, INV=3.
- `req_index_i` input $clog2(N): target index for WR and RD.
- `req_entry_i` input `tlb_entry_t`: entry payload for WR and FILL.
- `inv_op_i` input 5: INVTLB op code.
- `inv_asid_i` input 10: INVTLB ASID.
- `inv_va_i` input 32: INVTLB virtual address.
- `tlb_update_req_o` output `tlb_update_req_t`: one-hot `tlb_we[N]` plus `tlb_w_entry`; fans out to all translation units.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: qualifies `done_o`; high for an illegal INV op.
- `rd_entry_o` output `tlb_entry_t`: TLBRD result, valid while `done_o` is high for RD.
- `fill_index_o` output $clog2(N): index chosen by FILL, valid with `done_o`.

## Operation
- States: IDLE, WRITE, READ, SCAN.
- IDLE
  - Accept when `req_valid_i` is high.
  - Latch op, index, entry, inv fields.
  - WR goes to WRITE with target `req_index_i`.
  - FILL goes to WRITE with target = current value of the free-running counter.
  - RD goes to READ.
  - INV with `inv_op_i` ≤ 6 goes to SCAN with scan index = 0.
  - INV with any other op stays in IDLE and pulses `done_o` and `err_o` on the next cycle.
- Free-running counter: increments every cycle, mod N, from reset value 0.
- WRITE
  - Drive `tlb_we[target]` = 1 and `tlb_w_entry` = latched entry.
  - Update the shadow entry in the same cycle.
  - Pulse `done_o`, return to IDLE.
- READ
  - `rd_entry_o` = shadow[index].
  - Pulse `done_o`, return to IDLE.
- SCAN, one entry per cycle at scan index i:
  - If shadow[i].key.e is set and the predicate holds, drive `tlb_we[i]` with `tlb_w_entry` = shadow[i] with e=0, and clear the shadow e bit.
  - On i = N-1, pulse `done_o` and return to IDLE.
- INV predicates:
  - op 0 and op 1: all entries.
  - op 2: g=1.
  - op 3: g=0.
  - op 4: g=0 and asid matches.
  - op 5: g=0 and asid matches and va matches.
  - op 6: (g=1 or asid matches) and va matches.
- VA match: compare `inv_va_i[31:23]` against vppn[18:10]. Also compare `[22:13]` against vppn[9:0] only when ps=12.
- Entries with e=0 are never written during a scan.
- New requests are ignored outside IDLE (`req_ready_o`=0).

## Timing
- Reset values:
  - State = IDLE, `req_ready_o`=1.
  - `tlb_we`='0, `tlb_w_entry`='0.
  - `done_o`=0, `err_o`=0, `rd_entry_o`='0, `fill_index_o`=0.
  - Every shadow e bit = 0, fill counter = 0.
- Latency from the acceptance edge:
  - WR, FILL, RD: `done_o` in cycle +1.
  - Illegal INV: `done_o` in cycle +1.
  - INV: writes occur in cycles +1..+N; `done_o` in cycle +N.
- `tlb_update_req_o` is registered. Translation units see the new entry at the edge ending the `done_o` cycle.
- At most one `tlb_we` bit is high per cycle.
- Reset asserted mid-SCAN or mid-WRITE aborts immediately: outputs return to reset values and no partial write is retried.
- A request presented in the same cycle as `done_o` is not accepted, because `req_ready_o` is low. It is accepted on the following cycle.

## Structure
- The shared pipeline package provides:
  - `tlb_entry_t`: key {vppn[18:0], ps[5:0], g, asid[9:0], e} and value[2] {ppn[19:0], plv[1:0], mat[1:0], d, v}.
  - `tlb_update_req_t`.
  - `tlb_op_e`.
  - INVTLB op constants.
- One natural sub-module: `tlb_inv_match`, a combinational predicate taking key, op, asid and va, returning 1 bit. It is reusable by TLBSRCH logic.

## Test plan
- WR with index 5, entry vppn=0x12345, asid=3, e=1 → `tlb_we`=1<<5 in cycle +1; `done_o`=1; a following RD of index 5 returns the identical entry.
- FILL accepted when the counter is 7 → `fill_index_o`=7, `tlb_we`=1<<7, `done_o` at +1.
- Fill entries 0..3: entry 1 with g=1, entries 0 and 2 with asid=4, entry 3 with asid=5. Then INV op 4, asid=4 → writes only to indices 0 and 2 with e=0; `done_o` at +N.
- INV op 5, asid=4, va=0x00400000 against a 4M entry (ps=22, vppn=0x00200) and a 4K entry (vppn=0x00201) → only the 4M entry is invalidated.
- INV op 9 → `done_o`=`err_o`=1 at +1, no `tlb_we`.
- Assert `rst_n`=0 at scan index 10 → `tlb_we`=0 immediately; after release `req_ready_o`=1 and RD of any index returns e=0.
